// File: rtl/range_burst_feeder.sv
// Frame-buffering feeder: stores valid/ready beats in a FIFO and replays each
// complete frame as a stall-free burst framed by go/finish.
module range_burst_feeder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             frame_drop,
  output logic             frame_trunc,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] LastLen   = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e           r_state;
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      r_wr_len;
  logic [AW:0]      r_frames;
  logic             r_discard;
  logic [WIDTH-1:0] r_data_out;
  logic             r_go;
  logic             r_finish;
  logic             r_frame_drop;
  logic             r_frame_trunc;

  logic           w_full;
  logic           w_accept;
  logic           w_drop;
  logic           w_write;
  logic           w_trunc;
  logic           w_wr_last;
  logic [WIDTH:0] w_head;
  logic           w_pop;
  logic           w_pop_last;

  assign w_full     = (r_count == FullCount);
  assign in_ready   = r_discard | ~w_full;
  assign w_accept   = in_valid & in_ready;
  assign w_drop     = w_accept & ~r_discard & in_last & (r_wr_len == '0);
  assign w_write    = w_accept & ~r_discard & ~w_drop;
  // The DEPTH-th beat of an unterminated frame closes it so a full FIFO always drains.
  assign w_trunc    = w_write & ~in_last & (r_wr_len == LastLen);
  assign w_wr_last  = in_last | w_trunc;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop      = ((r_state == StIdle) && (r_frames != '0)) || (r_state == StRun);
  assign w_pop_last = w_pop & w_head[WIDTH];

  assign data_out    = r_data_out;
  assign go          = r_go;
  assign finish      = r_finish;
  assign frame_drop  = r_frame_drop;
  assign frame_trunc = r_frame_trunc;
  assign busy        = (r_state != StIdle) | (r_frames != '0);

  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= {w_wr_last, in_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_wr_len      <= '0;
      r_discard     <= 1'b0;
      r_frame_drop  <= 1'b0;
      r_frame_trunc <= 1'b0;
    end else begin
      r_frame_drop  <= w_drop;
      r_frame_trunc <= w_trunc;
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_wr_len <= w_wr_last ? '0 : r_wr_len + (AW+1)'(1);
      end
      if (w_accept && r_discard && in_last) begin
        r_discard <= 1'b0;
        r_wr_len  <= '0;
      end else if (w_trunc) begin
        r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_frames <= '0;
    end else begin
      r_count <= r_count + (AW+1)'(w_write) - (AW+1)'(w_pop);
      unique case ({w_write & w_wr_last, w_pop_last})
        2'b10:   r_frames <= r_frames + (AW+1)'(1);
        2'b01:   r_frames <= r_frames - (AW+1)'(1);
        default: r_frames <= r_frames;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
      r_go       <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_data_out <= w_head[WIDTH-1:0];
      end
      unique case (r_state)
        StIdle: begin
          if (r_frames != '0) begin
            r_go    <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_head[WIDTH]) begin
            r_finish <= 1'b1;
            r_state  <= StGap;
          end
        end
        StGap:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_range_burst_feeder.sv
// Scoreboard bench for range_burst_feeder (DEPTH=8): expected burst beats are
// queued as frames are driven and compared as the feeder emits them.
module tb_range_burst_feeder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic             go;
    logic             fin;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             frame_drop;
  logic             frame_trunc;
  logic             busy;

  range_burst_feeder #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .go         (go),
    .finish     (finish),
    .frame_drop (frame_drop),
    .frame_trunc(frame_trunc),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  exp_t             sb[$];
  logic [WIDTH-1:0] fr[$];
  int               n_vec;
  int               n_err;
  int               cyc;
  int               n_drop;
  int               n_trunc;
  int               n_stall;
  int               go_cyc;
  int               fin_cyc;
  int               last_gap;
  int               last_acc_cyc;
  logic             in_burst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock, then sample the outputs #1 after the edge.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (!reset) begin
      if (frame_drop)  n_drop++;
      if (frame_trunc) n_trunc++;
      if (go || in_burst) begin
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("beat", {go, finish, data_out}, {e.go, e.fin, e.data});
        end
        if (go) begin
          last_gap = cyc - fin_cyc;
          go_cyc   = cyc;
        end
        if (finish) fin_cyc = cyc;
        in_burst = !finish;
      end else if (finish) begin
        check_eq("stray_finish", finish, 0);
      end
    end
  endtask

  // Queue the expected burst for fr[], then drive it beat by beat.
  task automatic send_frame();
    int   n;
    int   m;
    int   tries;
    logic rdy;
    exp_t e;
    n = fr.size();
    m = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    if (n > 1) begin
      for (int i = 0; i < m; i++) begin
        e.go   = (i == 0);
        e.fin  = (i == m - 1);
        e.data = fr[i];
        sb.push_back(e);
      end
    end
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = fr[i];
      in_last  = (i == n - 1);
      if (i >= int'(DEPTH)) check_eq("discard_ready", in_ready, 1);
      tries = 0;
      do begin
        rdy = in_ready;
        if (!rdy) n_stall++;
        step();
        tries++;
      end while (!rdy && tries < 100);
      if (!rdy) check_eq("accept_timeout", rdy, 1);
      last_acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && (sb.size() != 0 || in_burst); k++) step();
    if (sb.size() != 0 || in_burst) check_eq("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    clock    = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    n_drop   = 0;
    n_trunc  = 0;
    n_stall  = 0;
    go_cyc   = 0;
    fin_cyc  = 0;
    last_gap = 0;
    in_burst = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_go", go, 0);
    check_eq("rst_finish", finish, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drop", frame_drop, 0);
    check_eq("rst_trunc", frame_trunc, 0);
    step();

    // Basic 4-beat burst.
    fr = '{16'd10, 16'd20, 16'd5, 16'd30};
    send_frame();
    wait_drain();
    check_eq("go_latency", go_cyc - last_acc_cyc, 1);
    check_eq("burst_len", fin_cyc - go_cyc, 3);
    check_eq("busy_in_gap", busy, 1);
    step();
    check_eq("busy_after_gap", busy, 0);

    // Single-beat frame is discarded, then a 2-beat frame.
    fr = '{16'd7};
    send_frame();
    repeat (4) step();
    check_eq("drop_count", n_drop, 1);
    check_eq("drop_busy", busy, 0);
    fr = '{16'd3, 16'd9};
    send_frame();
    wait_drain();
    repeat (2) step();

    // Truncation of an 11-beat frame at DEPTH.
    fr = {};
    for (int i = 1; i <= 11; i++) fr.push_back(WIDTH'(i));
    send_frame();
    wait_drain();
    repeat (2) step();
    check_eq("trunc_count", n_trunc, 1);
    check_eq("trunc_ready", in_ready, 1);
    check_eq("trunc_drop", n_drop, 1);

    // Two buffered frames separated by exactly one idle cycle.
    fr = '{16'd1, 16'd2, 16'd3};
    send_frame();
    fr = '{16'd4, 16'd5};
    send_frame();
    wait_drain();
    check_eq("b2b_gap", last_gap, 2);
    repeat (2) step();

    // Backpressure: three 7-beat frames back to back fill the FIFO.
    n_stall = 0;
    for (int f = 0; f < 3; f++) begin
      fr = {};
      for (int i = 0; i < 7; i++) fr.push_back(WIDTH'(100 * (f + 1) + i));
      send_frame();
    end
    wait_drain();
    check_eq("bp_stalled", (n_stall > 0), 1);
    repeat (2) step();
    check_eq("bp_ready", in_ready, 1);
    check_eq("bp_trunc", n_trunc, 1);

    // Reset on the third cycle of a 6-beat burst.
    fr = '{16'd50, 16'd51, 16'd52, 16'd53, 16'd54, 16'd55};
    send_frame();
    for (int k = 0; k < 30 && go !== 1'b1; k++) step();
    check_eq("rst_go_seen", go, 1);
    step();
    step();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_data", data_out, 0);
    check_eq("mid_rst_go", go, 0);
    check_eq("mid_rst_finish", finish, 0);
    check_eq("mid_rst_busy", busy, 0);
    sb.delete();
    in_burst = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", in_ready, 1);
    check_eq("post_rst_busy", busy, 0);
    step();
    fr = '{16'd60, 16'd61};
    send_frame();
    wait_drain();
    step();
    check_eq("post_rst_idle", busy, 0);
    repeat (6) step();
    check_eq("post_rst_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/range_burst_feeder.md
# range_burst_feeder

Upstream framing stage for the range-finding datapath. It accepts samples on a valid/ready stream with an end-of-frame flag and buffers them in a FIFO. Once a frame is complete, it replays it as a contiguous burst: go on the first sample, one sample per cycle, finish on the last. Frames are replayed only when complete, so the range stage never sees a stall in the middle of a burst.

## Interface
- WIDTH, 16, sample width
- DEPTH, 32, FIFO depth in samples and maximum frame length; power of two, at least 4

- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH  sample
- in_valid  in  1  sample present
- in_last  in  1  sample is last of its frame
- in_ready  out  1  feeder can accept; a beat transfers when in_valid & in_ready
- data_out  out  WIDTH  burst sample
- go  out  1  first sample of a burst
- finish  out  1  last sample of a burst
- frame_drop  out  1  one-cycle pulse when a single-beat frame is discarded
- frame_trunc  out  1  one-cycle pulse when a frame is truncated at DEPTH beats
- busy  out  1  burst in progress or a complete frame is pending

## Operation
- **Storage:** FIFO of DEPTH entries, each {last, data}, plus write pointer, read pointer and occupancy.
- **Write side:** frame-length counter wr_len (0..DEPTH) and a DISCARD flag.
  - Beat with in_last and wr_len==0: not written; frame_drop pulses. Bursts are at least 2 samples because go and finish are never asserted together.
  - Beat written with wr_len==DEPTH-1 and in_last=0: stored with last forced to 1; frame_trunc pulses; DISCARD is set.
  - In DISCARD, in_ready=1 and beats are dropped. The beat carrying in_last clears DISCARD and resets wr_len to 0.
  - Otherwise, in_ready = !full. Each written beat increments wr_len; a written last beat resets it to 0.
- **Frame counter:** frames_ready (width clog2(DEPTH)+1).
  - +1 when a last entry is written; -1 when a last entry is popped.
  - A simultaneous +1 and -1 leaves it unchanged.
- **Emitter FSM:** states IDLE, RUN, GAP.
  - IDLE: if frames_ready>0, pop the head, register it to data_out, assert go, and go to RUN.
  - RUN: pop one entry per cycle onto data_out. If the entry has last set, assert finish and go to GAP.
  - GAP: go=finish=0 for exactly one cycle, then return to IDLE.
- **Outputs:** data_out holds the last emitted value while not in a burst. go, finish, frame_drop and frame_trunc are registered.
- **Full FIFO:** a full FIFO always contains at least one complete frame, because truncation bounds partial frames to DEPTH-1 stored entries plus the forced last. Draining therefore always frees space; no deadlock.
- **Reset:**
  - Clears pointers, counters, DISCARD and FSM (to IDLE).
  - data_out=0, go=finish=frame_drop=frame_trunc=busy=0; in_ready=1 after reset.
  - Reset mid-burst abandons the burst without finish; the downstream stage is reset by the same signal.

## Timing
- The last beat of a frame accepted at edge t makes frames_ready>0 after t. With the FSM idle and nothing pending, go is high in the cycle after t+1.
- An N-beat frame occupies N consecutive cycles: go on cycle 1, finish on cycle N. A GAP cycle always follows, so back-to-back bursts are separated by exactly one idle cycle.
- in_ready is combinational from full and DISCARD. Full is computed from registered occupancy; a pop in the same cycle does not raise in_ready until the next cycle.
- A write and a pop in the same cycle are both performed; occupancy is unchanged.
- frame_drop and frame_trunc are high the cycle after the offending beat is accepted.

## Test plan
- **Basic burst:** 4-beat frame 10,20,5,30 (last on 30) with ready high.
  - go with data_out=10 two edges after the last beat.
  - Then 20 and 5, then 30 with finish.
  - No gaps; busy falls after GAP.
- **Single-beat frame:** single beat 7 with in_last.
  - frame_drop pulses once; no go; FIFO remains empty.
  - A following 2-beat frame 3,9 bursts normally.
- **Truncation (DEPTH=8):** 11-beat frame 1..11.
  - Burst of 1..8 with finish on 8; frame_trunc pulses once.
  - Beats 9..11 are accepted with in_ready=1 and dropped.
- **Back-to-back frames:** frames {1,2,3} and {4,5} both buffered.
  - Burst 1,2,3 (finish on 3), one idle cycle, then go on 4 and finish on 5.
- **Backpressure (DEPTH=8):** hold in_valid while a 7-beat frame is still bursting.
  - in_ready drops at full and recovers as entries pop.
  - No beat is lost or duplicated; data order is preserved.
- **Reset mid-burst:** assert reset on the third cycle of a 6-beat burst.
  - Outputs are 0 immediately and no finish is seen.
  - After release, a new 2-beat frame bursts correctly and frames_ready starts from 0.
